// File: rtl/afe_adc_capture_if.sv
// afe_adc_capture_if: ADS8363 serial link plus pixel output stream of afe_adc_capture.
// master = capture block, slave = ADC / pixel consumer side.
interface afe_adc_capture_if #(
  parameter int DATA_BITS = 16
);
  logic                 adc_convst;
  logic                 adc_cs_n;
  logic                 adc_sclk;
  logic                 adc_sdo;
  logic [DATA_BITS-1:0] pix_data;
  logic [5:0]           pix_chan;
  logic                 pix_valid;
  logic                 frame_done;

  modport master (
    output adc_convst, adc_cs_n, adc_sclk,
    input  adc_sdo,
    output pix_data, pix_chan, pix_valid, frame_done
  );

  modport slave (
    input  adc_convst, adc_cs_n, adc_sclk,
    output adc_sdo,
    input  pix_data, pix_chan, pix_valid, frame_done
  );
endinterface

// File: rtl/afe_adc_capture.sv
// afe_adc_capture: per-channel ADS8363 conversion/readout sequenced by AFE_CLK rises.
// Optional AFE_SKIP_FIRST_EN: first capture after each frame_start is a dummy.
module afe_adc_capture #(
  parameter int NUM_CH     = 64,
  parameter int DATA_BITS  = 16,
  parameter int SETTLE_CYC = 8,
  parameter int CONV_PULSE = 4,
  parameter int CONV_WAIT  = 40,
  parameter int SCLK_HALF  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              afe_clk,
  output logic              overrun,
  afe_adc_capture_if.master bus
);
`ifdef AFE_SKIP_FIRST_EN
  localparam logic SKIP_FIRST = 1'b1;
`else
  localparam logic SKIP_FIRST = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, ARMED, SETTLE, CONV, CWAIT, SHIFT, DONE} state_t;

  state_t               state_q, state_d;
  logic [2:0]           sync_q;
  logic                 rise;
  logic [15:0]          cnt_q, cnt_d;
  logic [7:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d, pdata_q, pdata_d;
  logic [5:0]           chan_q, chan_d, pchan_q, pchan_d;
  logic                 pvalid_q, pvalid_d, fdone_q, fdone_d, ovr_q, ovr_d;
  logic                 convst_q, convst_d, csn_q, csn_d, sclk_q, sclk_d;
  logic                 skip_q, skip_d;
  logic                 emit;

  // Two sync flops, third flop only for edge detection.
  assign rise = sync_q[1] & ~sync_q[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sync_q   <= '0;
      cnt_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      chan_q   <= '0;
      skip_q   <= 1'b0;
      pdata_q  <= '0;
      pchan_q  <= '0;
      pvalid_q <= 1'b0;
      fdone_q  <= 1'b0;
      ovr_q    <= 1'b0;
      convst_q <= 1'b0;
      csn_q    <= 1'b1;
      sclk_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      sync_q   <= {sync_q[1:0], afe_clk};
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      chan_q   <= chan_d;
      skip_q   <= skip_d;
      pdata_q  <= pdata_d;
      pchan_q  <= pchan_d;
      pvalid_q <= pvalid_d;
      fdone_q  <= fdone_d;
      ovr_q    <= ovr_d;
      convst_q <= convst_d;
      csn_q    <= csn_d;
      sclk_q   <= sclk_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    chan_d  = chan_q;
    skip_d  = skip_q;
    ovr_d   = ovr_q;
    sclk_d  = 1'b1;
    pdata_d = pdata_q;
    pchan_d = pchan_q;

    case (state_q)
      IDLE: if (frame_start) begin
        state_d = ARMED;
        chan_d  = '0;
      end
      ARMED: if (rise) begin
        state_d = SETTLE;
        cnt_d   = '0;
      end
      SETTLE: if (cnt_q == 16'(SETTLE_CYC - 1)) begin
        state_d = CONV;
        cnt_d   = '0;
      end else cnt_d = cnt_q + 16'd1;
      CONV: if (cnt_q == 16'(CONV_PULSE - 1)) begin
        state_d = CWAIT;
        cnt_d   = '0;
      end else cnt_d = cnt_q + 16'd1;
      CWAIT: if (cnt_q == 16'(CONV_WAIT - 1)) begin
        state_d = SHIFT;
        cnt_d   = '0;
        bit_d   = '0;
        sclk_d  = 1'b0;
      end else cnt_d = cnt_q + 16'd1;
      SHIFT: begin
        sclk_d = sclk_q;
        if (cnt_q == 16'(SCLK_HALF - 1)) begin
          cnt_d  = '0;
          sclk_d = ~sclk_q;
          // Sample on the low->high sclk transition; a bit ends on high->low.
          if (!sclk_q) shreg_d = {shreg_q[DATA_BITS-2:0], bus.adc_sdo};
          else begin
            bit_d = bit_q + 8'd1;
            if (bit_q == 8'(DATA_BITS - 1)) state_d = DONE;
          end
        end else cnt_d = cnt_q + 16'd1;
      end
      DONE: begin
        if (skip_q) begin
          skip_d  = 1'b0;
          state_d = ARMED;
        end else if (chan_q == 6'(NUM_CH - 1)) begin
          state_d = IDLE;
          chan_d  = '0;
        end else begin
          state_d = ARMED;
          chan_d  = chan_q + 6'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (rise && state_q != IDLE && state_q != ARMED) ovr_d = 1'b1;
    if (frame_start && state_q != IDLE) begin
      state_d = ARMED;
      chan_d  = '0;
    end
    if (frame_start) skip_d = SKIP_FIRST;

    // Interface outputs are registered from the next state so they switch glitch-free.
    if (state_d != SHIFT) sclk_d = 1'b1;
    emit     = (state_d == DONE) && !skip_q;
    convst_d = (state_d == CONV);
    csn_d    = (state_d != SHIFT);
    pvalid_d = emit;
    fdone_d  = emit && (chan_q == 6'(NUM_CH - 1));
    if (emit) begin
      pdata_d = shreg_d;
      pchan_d = chan_q;
    end
  end

  assign bus.adc_convst = convst_q;
  assign bus.adc_cs_n   = csn_q;
  assign bus.adc_sclk   = sclk_q;
  assign bus.pix_data   = pdata_q;
  assign bus.pix_chan   = pchan_q;
  assign bus.pix_valid  = pvalid_q;
  assign bus.frame_done = fdone_q;
  assign overrun        = ovr_q;
endmodule

// File: tb/tb_afe_adc_capture.sv
// tb_afe_adc_capture: directed AFE_CLK/frame_start stimulus, an ADS8363 serial model,
// and a scoreboard of expected pixels checked every cycle.
`timescale 1ns/1ps
module tb_afe_adc_capture;
`ifdef AFE_SKIP_FIRST_EN
  localparam int SKIPN = 1;
`else
  localparam int SKIPN = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_start = 1'b0;
  logic afe_clk = 1'b0;
  logic overrun;

  afe_adc_capture_if #(.DATA_BITS(16)) bus ();

  afe_adc_capture #(
    .NUM_CH(64), .DATA_BITS(16), .SETTLE_CYC(8),
    .CONV_PULSE(4), .CONV_WAIT(40), .SCLK_HALF(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .afe_clk(afe_clk), .overrun(overrun), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [5:0]  c;
    logic        fd;
  } pix_t;

  pix_t        exp_q[$];
  pix_t        e;
  int          n_vec = 0;
  int          n_err = 0;
  int          pix_cnt = 0;
  int          fd_cnt = 0;
  int          pix0, fd0;
  logic [15:0] last_d = '0;
  logic [5:0]  last_c = '0;
  logic [5:0]  dut_last_c = '0;
  logic [15:0] adc_word = '0;
  int          m_chan = 0;
  bit          m_active = 1'b0;
  bit          m_skip = 1'b0;
  int          n, t, cst, cw, rises, csl, k;
  logic        ps, got, prev_s;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard: a frame is NUM_CH pixels, channels 0..63, optional dummy first.
  task automatic model_frame_start();
    m_chan   = 0;
    m_active = 1'b1;
    m_skip   = (SKIPN != 0);
  endtask

  task automatic model_rise(input logic [15:0] w);
    pix_t p;
    if (!m_active) return;
    if (m_skip) begin
      m_skip = 1'b0;
      return;
    end
    p.d  = w;
    p.c  = 6'(m_chan);
    p.fd = (m_chan == 63);
    exp_q.push_back(p);
    if (m_chan == 63) begin
      m_chan   = 0;
      m_active = 1'b0;
    end else m_chan++;
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    model_frame_start();
  endtask

  task automatic cap(input logic [15:0] w);
    adc_word = w;
    model_rise(w);
    afe_clk = 1'b1;
    tick(10);
    afe_clk = 1'b0;
    tick(190);
  endtask

  // ADS8363 model: MSB presented while CS_n is high, next bit after each SCLK rise.
  always @(negedge clk) begin
    if (bus.adc_cs_n) begin
      k = 0;
      prev_s = 1'b1;
      bus.adc_sdo = adc_word[15];
    end else begin
      if (bus.adc_sclk && !prev_s) begin
        k++;
        if (k < 16) bus.adc_sdo = adc_word[4'(15 - k)];
      end
      prev_s = bus.adc_sclk;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      last_d = '0;
      last_c = '0;
    end else begin
      if (bus.adc_cs_n) chk("sclk_idle_high", bus.adc_sclk, 1);
      if (bus.pix_valid) begin
        pix_cnt++;
        if (bus.frame_done) fd_cnt++;
        dut_last_c = bus.pix_chan;
        if (exp_q.size() == 0) chk("pix_unexpected", bus.pix_valid, 0);
        else begin
          e = exp_q.pop_front();
          chk("pix_data", bus.pix_data, e.d);
          chk("pix_chan", bus.pix_chan, e.c);
          chk("frame_done", bus.frame_done, e.fd);
          last_d = e.d;
          last_c = e.c;
        end
      end else begin
        chk("frame_done_no_valid", bus.frame_done, 0);
        chk("pix_data_hold", bus.pix_data, last_d);
        chk("pix_chan_hold", bus.pix_chan, last_c);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    tick(5);
    rst_n = 1'b1;
    tick(1);
    chk("rst_convst", bus.adc_convst, 0);
    chk("rst_cs_n", bus.adc_cs_n, 1);
    chk("rst_sclk", bus.adc_sclk, 1);
    chk("rst_pix_valid", bus.pix_valid, 0);
    chk("rst_pix_data", bus.pix_data, 0);
    chk("rst_pix_chan", bus.pix_chan, 0);
    chk("rst_frame_done", bus.frame_done, 0);
    chk("rst_overrun", overrun, 0);
    tick(1000);
    chk("idle_cs_n", bus.adc_cs_n, 1);
    chk("idle_convst", bus.adc_convst, 0);
    chk("idle_pix_cnt", pix_cnt, 0);

    // Single channel with timing measured from the pin edge.
    pulse_fs();
    for (int i = 0; i < SKIPN; i++) cap(16'h0000);
    adc_word = 16'hA5C3;
    model_rise(16'hA5C3);
    afe_clk = 1'b1;
    n = 0; cst = 0; cw = 0; rises = 0; csl = 0; ps = 1'b1; got = 1'b0;
    while (!got && n < 300) begin
      tick(1);
      n++;
      if (n == 10) afe_clk = 1'b0;
      if (bus.adc_convst) begin
        if (cw == 0) cst = n;
        cw++;
      end
      if (!bus.adc_cs_n) begin
        csl++;
        if (bus.adc_sclk && !ps) rises++;
      end
      ps = bus.adc_sclk;
      if (bus.pix_valid) begin
        got = 1'b1;
        chk("single_data", bus.pix_data, 16'hA5C3);
        chk("single_chan", bus.pix_chan, 0);
      end
    end
    afe_clk = 1'b0;
    chk("single_got", got, 1);
    chk("convst_latency", cst, 11);
    chk("convst_width", cw, 4);
    chk("sclk_rises", rises, 16);
    chk("cs_low_cycles", csl, 64);
    chk("pix_latency", n, 119);
    tick(100);

    // Full frame, ADC returns the channel number.
    pix0 = pix_cnt;
    fd0  = fd_cnt;
    pulse_fs();
    for (int i = 0; i < 64 + SKIPN; i++) cap(16'(m_chan));
    chk("frame_pix_cnt", pix_cnt - pix0, 64);
    chk("frame_done_cnt", fd_cnt - fd0, 1);
    chk("frame_q_empty", exp_q.size(), 0);
    cap(16'h7777);
    chk("idle_rise_pix", pix_cnt - pix0, 64);
    chk("idle_rise_ovr", overrun, 0);

    // Second rise lands in CWAIT.
    pix0 = pix_cnt;
    pulse_fs();
    adc_word = 16'h1234;
    model_rise(16'h1234);
    afe_clk = 1'b1; tick(10); afe_clk = 1'b0; tick(20);
    afe_clk = 1'b1; tick(10); afe_clk = 1'b0; tick(160);
    chk("overrun_set", overrun, 1);
    chk("overrun_pix", pix_cnt - pix0, 1 - SKIPN);
    tick(500);
    chk("overrun_sticky", overrun, 1);

    // Abort mid-SHIFT at channel 10.
    pix0 = pix_cnt;
    pulse_fs();
    for (int i = 0; i < 10 + SKIPN; i++) cap(16'(256 + i));
    chk("abort_pre_cnt", pix_cnt - pix0, 10);
    adc_word = 16'hBEEF;
    afe_clk = 1'b1; tick(10); afe_clk = 1'b0;
    t = 0;
    while (bus.adc_cs_n && t < 300) begin tick(1); t++; end
    chk("abort_reach_shift", bus.adc_cs_n, 0);
    tick(20);
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    model_frame_start();
    chk("abort_cs_n", bus.adc_cs_n, 1);
    chk("abort_sclk", bus.adc_sclk, 1);
    chk("abort_convst", bus.adc_convst, 0);
    tick(150);
    chk("abort_no_pix", pix_cnt - pix0, 10);
    for (int i = 0; i < 1 + SKIPN; i++) cap(16'h0ABC);
    chk("abort_next_cnt", pix_cnt - pix0, 11);
    chk("abort_next_chan", dut_last_c, 0);

    // Asynchronous reset in the middle of SHIFT.
    adc_word = 16'h3C3C;
    afe_clk = 1'b1; tick(10); afe_clk = 1'b0;
    t = 0;
    while (bus.adc_cs_n && t < 300) begin tick(1); t++; end
    chk("rst_reach_shift", bus.adc_cs_n, 0);
    tick(10);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_cs_n", bus.adc_cs_n, 1);
    chk("arst_sclk", bus.adc_sclk, 1);
    chk("arst_convst", bus.adc_convst, 0);
    chk("arst_pix_valid", bus.pix_valid, 0);
    chk("arst_overrun", overrun, 0);
    chk("arst_pix_data", bus.pix_data, 0);
    m_active = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);

    pix0 = pix_cnt;
    pulse_fs();
    for (int i = 0; i < 1 + SKIPN; i++) cap(16'h5A5A);
    chk("post_rst_cnt", pix_cnt - pix0, 1);
    chk("post_rst_chan", dut_last_c, 0);
    chk("final_q_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
